// File: rtl/mcdt_pkg.sv
// Shared definitions for the multi-channel data transfer block:
// arbitration mode encodings and the margin-width helper.
package mcdt_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Margin must represent 0..depth inclusive, hence one bit beyond the pointer width.
  function automatic int calc_mw(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/chnl_fifo.sv
// Per-channel synchronous FIFO with registered occupancy, full flag and
// free-slot margin; the head word is presented combinationally on rdata.
module chnl_fifo
  import mcdt_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  localparam int MW   = calc_mw(DEPTH),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [MW-1:0] margin
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [MW-1:0] count;
  logic [MW-1:0] count_nxt;
  logic          full_q;

  assign rdata  = mem[rd_ptr];
  assign full   = full_q;
  assign empty  = (count == '0);
  assign margin = MW'(DEPTH) - count;

  // A simultaneous push and pop leaves the occupancy unchanged.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count  <= count_nxt;
      full_q <= (count_nxt == MW'(DEPTH));
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mcdt_multi.sv
// Multi-channel data transfer: CH_NUM buffered input channels arbitrated
// (fixed priority or round-robin) into one registered output stream.
module mcdt_multi
  import mcdt_pkg::*;
#(
  parameter int CH_NUM     = 4,
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 32,
  parameter int ARB_MODE   = ARB_RR,
  localparam int MW        = calc_mw(FIFO_DEPTH),
  localparam int IW        = $clog2(CH_NUM)
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [CH_NUM-1:0]    ch_en_i,
  input  logic [CH_NUM*DW-1:0] ch_data_i,
  input  logic [CH_NUM-1:0]    ch_valid_i,
  output logic [CH_NUM-1:0]    ch_ready_o,
  output logic [CH_NUM*MW-1:0] ch_margin_o,
  input  logic                 mcdt_ready_i,
  output logic [DW-1:0]        mcdt_data_o,
  output logic                 mcdt_val_o,
  output logic [IW-1:0]        mcdt_id_o
);

  logic [CH_NUM-1:0] fifo_full;
  logic [CH_NUM-1:0] fifo_empty;
  logic [CH_NUM-1:0] fifo_push;
  logic [CH_NUM-1:0] fifo_pop;
  logic [CH_NUM-1:0] eligible;
  logic [DW-1:0]     head_data [CH_NUM];
  logic [IW-1:0]     last_grant;
  logic [IW-1:0]     grant_idx;
  logic              grant_vld;
  logic              slot_free;
  int                start_idx;
  int                scan_idx;

  // Ready depends only on registered full, never on a same-cycle pop.
  assign ch_ready_o = ch_en_i & ~fifo_full;
  assign fifo_push  = ch_valid_i & ch_ready_o;
  assign eligible   = ch_en_i & ~fifo_empty;
  assign slot_free  = ~mcdt_val_o | mcdt_ready_i;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_chnl
    chnl_fifo #(
      .DW    (DW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk    (clk_i),
      .rstn   (rstn_i),
      .push   (fifo_push[k]),
      .pop    (fifo_pop[k]),
      .wdata  (ch_data_i[k*DW +: DW]),
      .rdata  (head_data[k]),
      .full   (fifo_full[k]),
      .empty  (fifo_empty[k]),
      .margin (ch_margin_o[k*MW +: MW])
    );
  end

  // Fixed mode scans downward so the lowest eligible index is the last to win.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    start_idx = 0;
    scan_idx  = 0;
    if (ARB_MODE == ARB_FIXED) begin
      for (int i = CH_NUM - 1; i >= 0; i--) begin
        if (eligible[IW'(i)]) begin
          grant_vld = 1'b1;
          grant_idx = IW'(i);
        end
      end
    end else begin
      start_idx = (int'(last_grant) + 1) % CH_NUM;
      for (int i = 0; i < CH_NUM; i++) begin
        scan_idx = start_idx + i;
        if (scan_idx >= CH_NUM) scan_idx = scan_idx - CH_NUM;
        if (!grant_vld && eligible[IW'(scan_idx)]) begin
          grant_vld = 1'b1;
          grant_idx = IW'(scan_idx);
        end
      end
    end
  end

  always_comb begin
    fifo_pop = '0;
    if (grant_vld && slot_free) fifo_pop[grant_idx] = 1'b1;
  end

  // The output stage reloads only when the slot is free, so data and id hold under backpressure.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mcdt_val_o  <= 1'b0;
      mcdt_data_o <= '0;
      mcdt_id_o   <= '0;
      last_grant  <= IW'(CH_NUM - 1);
    end else if (slot_free) begin
      if (grant_vld) begin
        mcdt_val_o  <= 1'b1;
        mcdt_data_o <= head_data[grant_idx];
        mcdt_id_o   <= grant_idx;
        last_grant  <= grant_idx;
      end else begin
        mcdt_val_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mcdt_multi.sv
// Scoreboard bench for mcdt_multi: one round-robin and one fixed-priority
// instance, directed stimulus with hand-computed expected output streams.
module tb_mcdt_multi;
  import mcdt_pkg::*;

  localparam int CH    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int MW    = 6;
  localparam int IW    = 2;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rstn = 1'b1;
  logic [CH-1:0]     ch_en;
  logic              mcdt_ready;
  logic [CH-1:0]     r_valid, f_valid;
  logic [CH*DW-1:0]  r_data, f_data;
  logic [CH-1:0]     r_ready, f_ready;
  logic [CH*MW-1:0]  r_margin, f_margin;
  logic [DW-1:0]     r_out_data, f_out_data;
  logic              r_out_val, f_out_val;
  logic [IW-1:0]     r_out_id, f_out_id;

  exp_t rr_q[$];
  exp_t fp_q[$];
  exp_t rr_e, fp_e;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  mcdt_multi #(.CH_NUM(CH), .DW(DW), .FIFO_DEPTH(DEPTH), .ARB_MODE(ARB_RR)) u_rr (
    .clk_i(clk), .rstn_i(rstn), .ch_en_i(ch_en), .ch_data_i(r_data),
    .ch_valid_i(r_valid), .ch_ready_o(r_ready), .ch_margin_o(r_margin),
    .mcdt_ready_i(mcdt_ready), .mcdt_data_o(r_out_data), .mcdt_val_o(r_out_val),
    .mcdt_id_o(r_out_id)
  );

  mcdt_multi #(.CH_NUM(CH), .DW(DW), .FIFO_DEPTH(DEPTH), .ARB_MODE(ARB_FIXED)) u_fp (
    .clk_i(clk), .rstn_i(rstn), .ch_en_i(ch_en), .ch_data_i(f_data),
    .ch_valid_i(f_valid), .ch_ready_o(f_ready), .ch_margin_o(f_margin),
    .mcdt_ready_i(mcdt_ready), .mcdt_data_o(f_out_data), .mcdt_val_o(f_out_val),
    .mcdt_id_o(f_out_id)
  );

  function automatic logic [DW-1:0] wordOf(input int ch, input int j);
    return 32'hA000_0000 | (32'(ch) << 16) | 32'(j);
  endfunction

  function automatic logic [MW-1:0] marginOf(input logic [CH*MW-1:0] m, input int k);
    return m[k*MW +: MW];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [CH-1:0] vr, input logic [CH-1:0] vf,
                               input logic [CH*DW-1:0] d);
    r_valid = vr;
    f_valid = vf;
    r_data  = d;
    f_data  = d;
    tick();
  endtask

  task automatic doReset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while ((rr_q.size() != 0 || fp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    checkOutput(name, 64'(rr_q.size() + fp_q.size()), 64'd0);
  endtask

  // Monitor: every accepted output word is matched against the head of its queue.
  always @(negedge clk) begin
    if (rstn && r_out_val && mcdt_ready) begin
      if (rr_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL rr_unexpected: got id %0d data 0x%0h, expected no output",
                 r_out_id, r_out_data);
      end else begin
        rr_e = rr_q.pop_front();
        checkOutput("rr_out", 64'({r_out_id, r_out_data}), 64'(rr_e));
      end
    end
    if (rstn && f_out_val && mcdt_ready) begin
      if (fp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL fp_unexpected: got id %0d data 0x%0h, expected no output",
                 f_out_id, f_out_data);
      end else begin
        fp_e = fp_q.pop_front();
        checkOutput("fp_out", 64'({f_out_id, f_out_data}), 64'(fp_e));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ch_en = 4'b1011;
    mcdt_ready = 1'b1;
    r_valid = '0; f_valid = '0; r_data = '0; f_data = '0;
    #1 rstn = 1'b0;
    #1;
    checkOutput("rst_val", 64'(r_out_val), 64'd0);
    checkOutput("rst_data", 64'(r_out_data), 64'd0);
    checkOutput("rst_id", 64'(r_out_id), 64'd0);
    checkOutput("rst_fp_val", 64'(f_out_val), 64'd0);
    for (int k = 0; k < CH; k++) checkOutput("rst_margin", 64'(marginOf(r_margin, k)), 64'd32);
    checkOutput("rst_ready_en", 64'(r_ready), 64'b1011);
    tick();
    tick();
    ch_en = 4'hF;
    #1 checkOutput("rst_ready_en2", 64'(r_ready), 64'hF);
    rstn = 1'b1;

    // Single write: visible on the output after the second edge.
    r_data[31:0] = 32'h00C0_0000;
    r_valid = 4'b0001;
    rr_q.push_back('{id: 2'd0, data: 32'h00C0_0000});
    tick();
    r_valid = '0;
    checkOutput("single_val_early", 64'(r_out_val), 64'd0);
    checkOutput("single_margin31", 64'(marginOf(r_margin, 0)), 64'd31);
    tick();
    checkOutput("single_val", 64'(r_out_val), 64'd1);
    checkOutput("single_data", 64'(r_out_data), 64'h00C0_0000);
    checkOutput("single_id", 64'(r_out_id), 64'd0);
    checkOutput("single_margin32", 64'(marginOf(r_margin, 0)), 64'd32);
    tick();
    checkOutput("single_drained", 64'(rr_q.size()), 64'd0);

    // Round-robin vs fixed priority with all four channels streaming.
    doReset();
    for (int j = 0; j < 8; j++)
      for (int k = 0; k < CH; k++) rr_q.push_back('{id: IW'(k), data: wordOf(k, j)});
    for (int k = 0; k < CH; k++)
      for (int j = 0; j < 8; j++) fp_q.push_back('{id: IW'(k), data: wordOf(k, j)});
    for (int j = 0; j < 8; j++)
      applyStimulus(4'hF, 4'hF, {wordOf(3, j), wordOf(2, j), wordOf(1, j), wordOf(0, j)});
    r_valid = '0;
    f_valid = '0;
    repeat (26) tick();
    checkOutput("arb_rr_throughput", 64'(rr_q.size()), 64'd0);
    checkOutput("arb_fp_throughput", 64'(fp_q.size()), 64'd0);
    checkOutput("arb_rr_idle", 64'(r_out_val), 64'd0);
    checkOutput("arb_fp_idle", 64'(f_out_val), 64'd0);
    for (int k = 0; k < CH; k++) checkOutput("arb_fp_margin", 64'(marginOf(f_margin, k)), 64'd32);
    checkOutput("arb_fp_ready", 64'(f_ready), 64'hF);

    // Full and backpressure on channel 2 with the output slot already occupied.
    doReset();
    mcdt_ready = 1'b0;
    r_data[31:0] = 32'h0000_00B0;
    r_valid = 4'b0001;
    rr_q.push_back('{id: 2'd0, data: 32'h0000_00B0});
    tick();
    r_valid = '0;
    tick();
    checkOutput("bp_slot_val", 64'(r_out_val), 64'd1);
    for (int i = 0; i < 32; i++) begin
      r_data[95:64] = wordOf(2, i);
      r_valid = 4'b0100;
      rr_q.push_back('{id: 2'd2, data: wordOf(2, i)});
      tick();
    end
    checkOutput("bp_full_ready", 64'(r_ready), 64'b1011);
    checkOutput("bp_full_margin", 64'(marginOf(r_margin, 2)), 64'd0);
    checkOutput("bp_hold_data", 64'(r_out_data), 64'h0000_00B0);
    r_data[95:64] = wordOf(2, 32);
    rr_q.push_back('{id: 2'd2, data: wordOf(2, 32)});
    repeat (3) tick();
    checkOutput("bp_still_full", 64'(r_ready[2]), 64'd0);
    checkOutput("bp_hold_data2", 64'(r_out_data), 64'h0000_00B0);
    checkOutput("bp_hold_id", 64'(r_out_id), 64'd0);
    mcdt_ready = 1'b1;
    begin
      bit accepted = 1'b0;
      for (int c = 0; c < 10 && !accepted; c++) begin
        if (r_ready[2]) accepted = 1'b1;
        tick();
      end
      r_valid = '0;
      checkOutput("bp_33rd_accepted", 64'(accepted), 64'd1);
    end
    waitDrain("bp_drain", 100);
    tick();
    checkOutput("bp_idle", 64'(r_out_val), 64'd0);
    checkOutput("bp_margin_back", 64'(marginOf(r_margin, 2)), 64'd32);

    // Disabled channel keeps its contents but is skipped by the arbiter.
    doReset();
    mcdt_ready = 1'b0;
    r_data[31:0] = 32'h0000_00B1;
    r_valid = 4'b0001;
    rr_q.push_back('{id: 2'd0, data: 32'h0000_00B1});
    tick();
    r_valid = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      r_data[63:32] = wordOf(1, i);
      r_valid = 4'b0010;
      tick();
    end
    r_valid = '0;
    ch_en = 4'b1101;
    #1;
    checkOutput("en_ready_off", 64'(r_ready[1]), 64'd0);
    checkOutput("en_margin27", 64'(marginOf(r_margin, 1)), 64'd27);
    tick();
    for (int i = 0; i < 2; i++) begin
      r_data[127:96] = wordOf(3, i);
      r_valid = 4'b1000;
      rr_q.push_back('{id: 2'd3, data: wordOf(3, i)});
      tick();
    end
    r_valid = '0;
    mcdt_ready = 1'b1;
    repeat (10) tick();
    checkOutput("en_others_drained", 64'(rr_q.size()), 64'd0);
    checkOutput("en_idle_val", 64'(r_out_val), 64'd0);
    checkOutput("en_retained", 64'(marginOf(r_margin, 1)), 64'd27);
    for (int i = 0; i < 5; i++) rr_q.push_back('{id: 2'd1, data: wordOf(1, i)});
    ch_en = 4'hF;
    waitDrain("en_reenable_drain", 50);
    tick();
    checkOutput("en_margin32", 64'(marginOf(r_margin, 1)), 64'd32);

    // Reset in the middle of a burst discards everything immediately.
    mcdt_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r_data[95:64] = wordOf(2, 40 + i);
      r_valid = 4'b0100;
      tick();
    end
    checkOutput("mid_val_before", 64'(r_out_val), 64'd1);
    rstn = 1'b0;
    #1;
    checkOutput("mid_rst_val", 64'(r_out_val), 64'd0);
    checkOutput("mid_rst_data", 64'(r_out_data), 64'd0);
    checkOutput("mid_rst_id", 64'(r_out_id), 64'd0);
    for (int k = 0; k < CH; k++) checkOutput("mid_rst_margin", 64'(marginOf(r_margin, k)), 64'd32);
    checkOutput("mid_rst_ready", 64'(r_ready), 64'hF);
    r_valid = '0;
    tick();
    rstn = 1'b1;
    mcdt_ready = 1'b1;
    repeat (5) tick();
    checkOutput("mid_post_val", 64'(r_out_val), 64'd0);
    checkOutput("mid_post_margin", 64'(marginOf(r_margin, 2)), 64'd32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mcdt_multi.md
MCDT_MULTI -- requirements
Module: mcdt_multi

Interface
REQ-001 Parameter CH_NUM, default 4: number of input channels, range 2..8.
REQ-002 Parameter DW, default 32: data width in bits.
REQ-003 Parameter FIFO_DEPTH, default 32: per-channel FIFO depth, power of two, at least 4.
REQ-004 Parameter ARB_MODE, default 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-005 One clock, clk_i; reset is asynchronous and active-low, rstn_i.
REQ-006 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-007 rstn_i  input  1  asynchronous active-low reset.
REQ-008 ch_en_i  input  CH_NUM  per-channel enable.
REQ-009 ch_data_i  input  CH_NUM*DW  channel data; channel k occupies bits [k*DW +: DW].
REQ-010 ch_valid_i  input  CH_NUM  per-channel write request.
REQ-011 ch_ready_o  output  CH_NUM  per-channel write acceptance.
REQ-012 ch_margin_o  output  CH_NUM*MW  free slots per channel, with MW = $clog2(FIFO_DEPTH)+1.
REQ-013 mcdt_ready_i  input  1  downstream backpressure.
REQ-014 mcdt_data_o  output  DW  selected data.
REQ-015 mcdt_val_o  output  1  output valid.
REQ-016 mcdt_id_o  output  $clog2(CH_NUM)  source channel of mcdt_data_o.

Function
REQ-017 A channel write occurs on a rising edge where ch_valid_i[k] and ch_ready_o[k] are both 1.
REQ-018 ch_ready_o[k] SHALL equal ch_en_i[k] AND NOT full[k], where full[k] is the registered full flag; it SHALL NOT depend on a same-cycle pop.
REQ-019 ch_margin_o[k] SHALL equal FIFO_DEPTH minus the registered occupancy, and SHALL update on the edge following each push or pop.
REQ-020 A simultaneous push and pop on one channel SHALL leave occupancy and margin unchanged.
REQ-021 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; data order per channel is strictly FIFO.
REQ-022 The output slot is free when mcdt_val_o==0, or when mcdt_val_o==1 and mcdt_ready_i==1.
REQ-023 While the output slot is free, the arbiter SHALL grant exactly one channel that is non-empty and enabled.
- The granted FIFO pops on the same edge.
- The output registers load the popped data and id on that edge.
REQ-024 If no channel is eligible while the output slot is free, mcdt_val_o SHALL be 0 on the next cycle.
REQ-025 While mcdt_val_o==1 and mcdt_ready_i==0, mcdt_data_o and mcdt_id_o SHALL hold stable.
REQ-026 Latency: with the FIFO empty and the output slot free, a word written on edge N SHALL appear on mcdt_data_o after edge N+1.
REQ-027 Back-to-back operation: with mcdt_ready_i held at 1, throughput SHALL be one word per cycle.
REQ-028 Round-robin mode: the search SHALL start at (last_grant+1) mod CH_NUM, and last_grant SHALL update only on a grant.
REQ-029 Fixed-priority mode: the lowest eligible index SHALL win.
REQ-030 Disabled channel (ch_en_i[k]==0):
- ch_ready_o[k] is 0.
- The channel is excluded from arbitration.
- Its FIFO contents are retained.
- Margin continues to be reported.

Reset
REQ-031 While rstn_i==0, the following SHALL hold asynchronously:
- All FIFOs are emptied and ch_margin_o[k] = FIFO_DEPTH.
- mcdt_val_o = 0, mcdt_data_o = 0, mcdt_id_o = 0.
- last_grant = CH_NUM-1, so channel 0 is first after reset.
REQ-032 Reset asserted mid-transfer SHALL discard all buffered and output data; no partial word is emitted after release.
REQ-033 During reset, ch_ready_o[k] SHALL equal ch_en_i[k].

Structure
REQ-034 Package mcdt_pkg SHALL hold:
- the ARB_MODE encodings ARB_FIXED=0 and ARB_RR=1;
- a function computing MW from a depth.
REQ-035 The per-channel buffer SHALL be sub-module chnl_fifo, instantiated CH_NUM times in a generate loop.
REQ-036 The arbiter and output register stage SHALL reside in mcdt_multi.

Verification
REQ-037 Single write: reset, then ch0 writes 0x00C00000 with mcdt_ready_i=1 -> mcdt_val_o=1 with data 0x00C00000 and id 0 after the second edge; ch_margin_o[0] returns to 32.
REQ-038 Round-robin: all 4 channels hold valid continuously, ARB_MODE=1 -> id sequence 0,1,2,3,0,...; each channel's payload is in order.
REQ-039 Fixed priority: same stimulus with ARB_MODE=0 and mcdt_ready_i=1 -> only id 0 is emitted while ch0 stays non-empty.
REQ-040 Full/backpressure: mcdt_ready_i=0, ch2 writes 33 words -> after word 32 ch_ready_o[2]=0 and margin 0; the 33rd word is held by the driver; with ready=1 all words drain in order.
REQ-041 Enable/reset: disable ch1 with 5 words buffered -> no id 1 output and ch_ready_o[1]=0; re-enable -> 5 words are emitted; asserting rstn_i mid-burst -> val=0 and margins=32 immediately.
